// File: rtl/drive_pkg.sv
// Shared definitions for the drive phase scheduler.
// Contents: mission state codes, drive bus layout, fixed bus patterns.
package drive_pkg;

    localparam int unsigned BUS_W = 8;

    // Mission state codes (also the value seen on the phase output)
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_HANDOFF = 3'd2,
        ST_GOAL    = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_PAUSED  = 3'd5
    } state_e;

    // Drive bus layout, MSB first: {FWD_A, FWD_B, BWD_A, BWD_B, DutyA[1:0], DutyB[1:0]}
    typedef struct packed {
        logic       fwd_a;
        logic       fwd_b;
        logic       bwd_a;
        logic       bwd_b;
        logic [1:0] duty_a;
        logic [1:0] duty_b;
    } drive_bus_t;

    // Both motors in reverse at full duty (8'b0011_1111)
    localparam drive_bus_t BACKOFF_PATTERN = '{
        fwd_a:  1'b0,
        fwd_b:  1'b0,
        bwd_a:  1'b1,
        bwd_b:  1'b1,
        duty_a: 2'b11,
        duty_b: 2'b11
    };

    // Motors off
    localparam drive_bus_t IDLE_BUS = '0;

endpackage

// File: rtl/phase_timer.sv
// Shared phase timer for the drive phase scheduler.
// Up-counter with synchronous clear and freeze. It stops advancing once it
// reaches the terminal value, so a phase interrupted on its last cycle still
// matches when it resumes instead of running past the compare point.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   clear_i    in   force count to zero (wins over freeze)
//   freeze_i   in   hold the current count
//   terminal_i in   compare value (terminal count - 1)
//   match_c    out  combinational: count == terminal_i
module phase_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             freeze_i,
    input  logic [CNT_W-1:0] terminal_i,
    output logic             match_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign match_c = (cnt_q == terminal_i);

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (!freeze_i && !match_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/drive_phase_scheduler.sv
// Mission-level owner of the shared motor drive bus.
// Runs ball search, then goal seek, via enable/done handshakes with the two
// direction controllers, inserting a motors-off dead time between grants.
// Pause and boundary back-off override both controllers.
// Optional feature macro: GOAL_WATCHDOG_EN limits the GOAL phase to
// GOAL_TIMEOUT cycles and pulses wd_timeout on expiry; when undefined the
// GOAL phase is unbounded and wd_timeout stays 0.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   start         in   level, IDLE -> SEARCH
//   stop          in   level, any state -> IDLE
//   pause         in   level, freeze mission with motors off
//   inductance    in   boundary wire detected
//   ball_captured in   search complete
//   search_bus    in   drive bus from search controller
//   goal_bus      in   drive bus from goal controller
//   goal_done     in   goal controller done (high when idle)
//   en_search     out  search controller enable
//   en_goal       out  goal controller enable
//   motor_bus     out  granted drive bus
//   phase         out  current state code
//   wd_timeout    out  one-cycle pulse on goal watchdog expiry
module drive_phase_scheduler
    import drive_pkg::*;
#(
    parameter int unsigned HANDOFF_CYCLES = 10_000_000,
    parameter int unsigned BACKOFF_CYCLES = 200_000_000,
    parameter int unsigned GOAL_TIMEOUT   = 1_500_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             inductance,
    input  logic             ball_captured,
    input  logic [BUS_W-1:0] search_bus,
    input  logic [BUS_W-1:0] goal_bus,
    input  logic             goal_done,
    output logic             en_search,
    output logic             en_goal,
    output logic [BUS_W-1:0] motor_bus,
    output logic [2:0]       phase,
    output logic             wd_timeout
);

    localparam logic [CNT_W-1:0] HANDOFF_TC = CNT_W'(HANDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACKOFF_TC = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GOAL_TC    = CNT_W'(GOAL_TIMEOUT - 1);

    state_e     state_q, state_d;
    state_e     pause_ret_q, pause_ret_d;
    state_e     backoff_ret_q, backoff_ret_d;
    state_e     handoff_next_q, handoff_next_d;
    logic       goal_busy_q, goal_busy_d;
    logic       ball_pending_q, ball_pending_d;
    drive_bus_t motor_bus_q, motor_bus_d;
    logic       en_search_q, en_search_d;
    logic       en_goal_q, en_goal_d;
    logic       wd_timeout_q, wd_fire_c;

    logic             tmr_clear_c;
    logic             tmr_freeze_c;
    logic [CNT_W-1:0] tmr_term_c;
    logic             tmr_match_c;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (tmr_clear_c),
        .freeze_i   (tmr_freeze_c),
        .terminal_i (tmr_term_c),
        .match_c    (tmr_match_c)
    );

    // Timer compare value and run/freeze per current state
    always_comb begin
        tmr_freeze_c = 1'b1;
        tmr_term_c   = HANDOFF_TC;
        case (state_q)
            ST_HANDOFF: tmr_freeze_c = 1'b0;
            ST_BACKOFF: begin
                tmr_freeze_c = 1'b0;
                tmr_term_c   = BACKOFF_TC;
            end
            ST_GOAL: begin
                tmr_term_c = GOAL_TC;
`ifdef GOAL_WATCHDOG_EN
                tmr_freeze_c = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Next state; priority stop > pause > inductance > phase completion
    always_comb begin
        state_d        = state_q;
        pause_ret_d    = pause_ret_q;
        backoff_ret_d  = backoff_ret_q;
        handoff_next_d = handoff_next_q;
        goal_busy_d    = goal_busy_q;
        ball_pending_d = ball_pending_q;
        tmr_clear_c    = 1'b0;
        wd_fire_c      = 1'b0;

        if (stop) begin
            state_d        = ST_IDLE;
            goal_busy_d    = 1'b0;
            ball_pending_d = 1'b0;
            tmr_clear_c    = 1'b1;
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                state_d     = ST_SEARCH;
                tmr_clear_c = 1'b1;
            end
        end else if (state_q == ST_PAUSED) begin
            // Resume keeps the frozen timer value
            if (!pause) begin
                state_d = pause_ret_q;
            end
        end else if (pause) begin
            state_d     = ST_PAUSED;
            pause_ret_d = state_q;
            if (state_q == ST_SEARCH && ball_captured) begin
                ball_pending_d = 1'b1;
            end
        end else if (inductance && (state_q == ST_SEARCH || state_q == ST_GOAL)) begin
            state_d       = ST_BACKOFF;
            backoff_ret_d = state_q;
            tmr_clear_c   = 1'b1;
            // A capture that coincides with the boundary is serviced after back-off
            if (state_q == ST_SEARCH && ball_captured) begin
                ball_pending_d = 1'b1;
            end
            if (state_q == ST_GOAL && !goal_done) begin
                goal_busy_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (ball_captured || ball_pending_q) begin
                        state_d        = ST_HANDOFF;
                        handoff_next_d = ST_GOAL;
                        ball_pending_d = 1'b0;
                        tmr_clear_c    = 1'b1;
                    end
                end
                ST_HANDOFF: begin
                    if (tmr_match_c) begin
                        state_d     = handoff_next_q;
                        tmr_clear_c = 1'b1;
                    end
                end
                ST_GOAL: begin
                    // Done only counts after the controller has been seen busy
                    if (goal_done && goal_busy_q) begin
                        state_d        = ST_HANDOFF;
                        handoff_next_d = ST_SEARCH;
                        goal_busy_d    = 1'b0;
                        tmr_clear_c    = 1'b1;
`ifdef GOAL_WATCHDOG_EN
                    end else if (tmr_match_c) begin
                        state_d        = ST_HANDOFF;
                        handoff_next_d = ST_SEARCH;
                        goal_busy_d    = 1'b0;
                        tmr_clear_c    = 1'b1;
                        wd_fire_c      = 1'b1;
`endif
                    end else if (!goal_done) begin
                        goal_busy_d = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (tmr_match_c) begin
                        tmr_clear_c = 1'b1;
                        if (!inductance) begin
                            state_d = backoff_ret_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs follow the state being entered this edge
    always_comb begin
        motor_bus_d = IDLE_BUS;
        en_search_d = 1'b0;
        en_goal_d   = 1'b0;
        case (state_d)
            ST_SEARCH: begin
                en_search_d = 1'b1;
                motor_bus_d = drive_bus_t'(search_bus);
            end
            ST_GOAL: begin
                en_goal_d   = 1'b1;
                motor_bus_d = drive_bus_t'(goal_bus);
            end
            ST_BACKOFF: begin
                en_search_d = en_search_q;
                en_goal_d   = en_goal_q;
                motor_bus_d = BACKOFF_PATTERN;
            end
            ST_PAUSED: begin
                en_search_d = en_search_q;
                en_goal_d   = en_goal_q;
            end
            default: ;
        endcase
    end

    // State, flags and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pause_ret_q    <= ST_IDLE;
            backoff_ret_q  <= ST_IDLE;
            handoff_next_q <= ST_IDLE;
            goal_busy_q    <= 1'b0;
            ball_pending_q <= 1'b0;
            motor_bus_q    <= IDLE_BUS;
            en_search_q    <= 1'b0;
            en_goal_q      <= 1'b0;
            wd_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pause_ret_q    <= pause_ret_d;
            backoff_ret_q  <= backoff_ret_d;
            handoff_next_q <= handoff_next_d;
            goal_busy_q    <= goal_busy_d;
            ball_pending_q <= ball_pending_d;
            motor_bus_q    <= motor_bus_d;
            en_search_q    <= en_search_d;
            en_goal_q      <= en_goal_d;
            wd_timeout_q   <= wd_fire_c;
        end
    end

    assign en_search  = en_search_q;
    assign en_goal    = en_goal_q;
    assign motor_bus  = motor_bus_q;
    assign phase      = state_q;
    assign wd_timeout = wd_timeout_q;

endmodule

// File: tb/tb_drive_phase_scheduler.sv
// Bench for drive_phase_scheduler with short phase lengths
// (HANDOFF=4, BACKOFF=8, GOAL_TIMEOUT=50). Directed scenarios check against
// constants; a random run checks against a remaining-cycles mission model.
module tb_drive_phase_scheduler;
    import drive_pkg::*;

    localparam int unsigned HO = 4;
    localparam int unsigned BO = 8;
    localparam int unsigned GT = 50;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, inductance, ball_captured, goal_done;
    logic [7:0] search_bus, goal_bus, motor_bus;
    logic       en_search, en_goal, wd_timeout;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    drive_phase_scheduler #(
        .HANDOFF_CYCLES (HO),
        .BACKOFF_CYCLES (BO),
        .GOAL_TIMEOUT   (GT),
        .CNT_W          (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .inductance    (inductance),
        .ball_captured (ball_captured),
        .search_bus    (search_bus),
        .goal_bus      (goal_bus),
        .goal_done     (goal_done),
        .en_search     (en_search),
        .en_goal       (en_goal),
        .motor_bus     (motor_bus),
        .phase         (phase),
        .wd_timeout    (wd_timeout)
    );

    always #5 clk = ~clk;

    // Mission model: phases tracked as "cycles left" rather than an up-count
    state_e     m_st, m_nst, m_ret, m_bo_ret, m_next;
    int         m_left, m_wd_left;
    logic       m_busy, m_pend, m_wd, m_es, m_eg;
    logic [7:0] m_bus;

    task automatic model_step();
        m_nst = m_st;
        m_wd  = 1'b0;
        if (rst) begin
            m_st = ST_IDLE; m_busy = 1'b0; m_pend = 1'b0; m_left = 0; m_wd_left = 0;
            m_bus = 8'h00; m_es = 1'b0; m_eg = 1'b0;
            return;
        end
        if (stop) begin
            m_nst = ST_IDLE; m_busy = 1'b0; m_pend = 1'b0;
        end else if (m_st == ST_IDLE) begin
            if (start) m_nst = ST_SEARCH;
        end else if (m_st == ST_PAUSED) begin
            if (!pause) m_nst = m_ret;
        end else if (pause) begin
            if (m_st == ST_SEARCH && ball_captured) m_pend = 1'b1;
            if ((m_st == ST_HANDOFF || m_st == ST_BACKOFF) && m_left > 1) m_left--;
`ifdef GOAL_WATCHDOG_EN
            if (m_st == ST_GOAL && m_wd_left > 1) m_wd_left--;
`endif
            m_ret = m_st; m_nst = ST_PAUSED;
        end else if (inductance && (m_st == ST_SEARCH || m_st == ST_GOAL)) begin
            if (m_st == ST_SEARCH && ball_captured) m_pend = 1'b1;
            if (m_st == ST_GOAL && !goal_done) m_busy = 1'b1;
            m_bo_ret = m_st; m_nst = ST_BACKOFF;
        end else begin
            case (m_st)
                ST_SEARCH: if (ball_captured || m_pend) begin
                    m_pend = 1'b0; m_next = ST_GOAL; m_nst = ST_HANDOFF;
                end
                ST_HANDOFF: if (m_left == 1) m_nst = m_next; else m_left--;
                ST_GOAL: begin
                    if (goal_done && m_busy) begin
                        m_busy = 1'b0; m_next = ST_SEARCH; m_nst = ST_HANDOFF;
                    end else begin
`ifdef GOAL_WATCHDOG_EN
                        if (m_wd_left == 1) begin
                            m_wd = 1'b1; m_busy = 1'b0; m_next = ST_SEARCH; m_nst = ST_HANDOFF;
                        end else begin
                            m_wd_left--;
                            if (!goal_done) m_busy = 1'b1;
                        end
`else
                        if (!goal_done) m_busy = 1'b1;
`endif
                    end
                end
                ST_BACKOFF: begin
                    if (m_left == 1) begin
                        if (inductance) m_left = BO; else m_nst = m_bo_ret;
                    end else m_left--;
                end
                default: ;
            endcase
        end
        // Fresh budget on entry to a timed phase; resuming from a pause keeps it
        if (m_nst != m_st && m_st != ST_PAUSED && m_nst != ST_PAUSED) begin
            if (m_nst == ST_HANDOFF) m_left = HO;
            if (m_nst == ST_BACKOFF) m_left = BO;
            if (m_nst == ST_GOAL)    m_wd_left = GT;
        end
        case (m_nst)
            ST_SEARCH:  begin m_es = 1'b1; m_eg = 1'b0; m_bus = search_bus; end
            ST_GOAL:    begin m_es = 1'b0; m_eg = 1'b1; m_bus = goal_bus; end
            ST_BACKOFF: m_bus = 8'h3F;
            ST_PAUSED:  m_bus = 8'h00;
            default:    begin m_es = 1'b0; m_eg = 1'b0; m_bus = 8'h00; end
        endcase
        m_st = m_nst;
    endtask

    always @(posedge clk) model_step();

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: stop, start, capture, then wait out the hand-off into GOAL
    task automatic goto_goal();
        stop = 1'b1; cyc(); stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        ball_captured = 1'b1; cyc(); ball_captured = 1'b0;
        repeat (HO) cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; inductance = 1'b0;
        ball_captured = 1'b0; goal_done = 1'b1; search_bus = 8'hA5; goal_bus = 8'h5A;
        cyc(); cyc();
        checks++;
        if (phase !== ST_IDLE || motor_bus !== 8'h00 || en_search !== 1'b0 ||
            en_goal !== 1'b0 || wd_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset: phase=%0d bus=%h es=%b eg=%b wd=%b required 0 00 0 0 0",
                     phase, motor_bus, en_search, en_goal, wd_timeout);
        end
        rst = 1'b0;
        pause = 1'b1; cyc(); pause = 1'b0;
        checks++;
        if (phase !== ST_IDLE) begin
            errors++;
            $display("FAIL idle_pause: phase=%0d required %0d", phase, ST_IDLE);
        end
    endtask

    task automatic test_search_grant();
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (phase !== ST_SEARCH || en_search !== 1'b1 || en_goal !== 1'b0 || motor_bus !== 8'hA5) begin
            errors++;
            $display("FAIL search_grant: phase=%0d es=%b eg=%b bus=%h required 1 1 0 a5",
                     phase, en_search, en_goal, motor_bus);
        end
    endtask

    task automatic test_handoff_to_goal();
        ball_captured = 1'b1;
        for (int i = 0; i < int'(HO); i++) begin
            cyc(); ball_captured = 1'b0;
            checks++;
            if (phase !== ST_HANDOFF || motor_bus !== 8'h00 || en_search !== 1'b0 || en_goal !== 1'b0) begin
                errors++;
                $display("FAIL handoff_%0d: phase=%0d bus=%h es=%b eg=%b required 2 00 0 0",
                         i, phase, motor_bus, en_search, en_goal);
            end
        end
        cyc();
        checks++;
        if (phase !== ST_GOAL || en_goal !== 1'b1 || motor_bus !== 8'h5A) begin
            errors++;
            $display("FAIL goal_grant: phase=%0d eg=%b bus=%h required 3 1 5a", phase, en_goal, motor_bus);
        end
    endtask

    task automatic test_goal_done();
        logic bad;
        bad = 1'b0;
        goal_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (phase !== ST_GOAL) bad = 1'b1;
        end
        goal_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (phase !== ST_GOAL) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL goal_hold: left GOAL early, phase=%0d required %0d", phase, ST_GOAL);
        end
        goal_done = 1'b1;
        for (int i = 0; i < int'(HO); i++) begin
            cyc();
            checks++;
            if (phase !== ST_HANDOFF || motor_bus !== 8'h00 || en_goal !== 1'b0) begin
                errors++;
                $display("FAIL goal_handoff_%0d: phase=%0d bus=%h eg=%b required 2 00 0",
                         i, phase, motor_bus, en_goal);
            end
        end
        cyc();
        checks++;
        if (phase !== ST_SEARCH || en_search !== 1'b1 || motor_bus !== 8'hA5) begin
            errors++;
            $display("FAIL back_to_search: phase=%0d es=%b bus=%h required 1 1 a5", phase, en_search, motor_bus);
        end
    endtask

    task automatic test_backoff();
        logic back;
        goal_done = 1'b0;
        goto_goal();
        inductance = 1'b1;
        for (int i = 0; i < int'(BO); i++) begin
            cyc(); inductance = 1'b0;
            checks++;
            if (phase !== ST_BACKOFF || motor_bus !== 8'h3F || en_goal !== 1'b1) begin
                errors++;
                $display("FAIL backoff_%0d: phase=%0d bus=%h eg=%b required 4 3f 1", i, phase, motor_bus, en_goal);
            end
        end
        cyc();
        checks++;
        if (phase !== ST_GOAL || motor_bus !== 8'h5A) begin
            errors++;
            $display("FAIL backoff_return: phase=%0d bus=%h required 3 5a", phase, motor_bus);
        end
        inductance = 1'b1;
        back = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (phase !== ST_BACKOFF) back = 1'b1;
        end
        checks++;
        if (back) begin
            errors++;
            $display("FAIL backoff_held: phase=%0d required %0d while boundary held", phase, ST_BACKOFF);
        end
        inductance = 1'b0;
        back = 1'b0;
        for (int i = 0; i < int'(BO) + 2 && !back; i++) begin
            cyc();
            if (phase === ST_GOAL) back = 1'b1;
        end
        checks++;
        if (!back) begin
            errors++;
            $display("FAIL backoff_release: phase=%0d required %0d within %0d clks", phase, ST_GOAL, BO + 2);
        end
    endtask

    task automatic test_pause_backoff();
        goal_done = 1'b0;
        goto_goal();
        inductance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); inductance = 1'b0;
        end
        checks++;
        if (phase !== ST_BACKOFF || motor_bus !== 8'h3F) begin
            errors++;
            $display("FAIL pre_pause: phase=%0d bus=%h required 4 3f", phase, motor_bus);
        end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (phase !== ST_PAUSED || motor_bus !== 8'h00 || en_goal !== 1'b1) begin
                errors++;
                $display("FAIL paused_%0d: phase=%0d bus=%h eg=%b required 5 00 1", i, phase, motor_bus, en_goal);
            end
        end
        pause = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (phase !== ST_BACKOFF || motor_bus !== 8'h3F) begin
                errors++;
                $display("FAIL resume_backoff_%0d: phase=%0d bus=%h required 4 3f", i, phase, motor_bus);
            end
        end
        cyc();
        checks++;
        if (phase !== ST_GOAL || motor_bus !== 8'h5A) begin
            errors++;
            $display("FAIL resume_goal: phase=%0d bus=%h required 3 5a", phase, motor_bus);
        end
    endtask

    task automatic test_ball_pending();
        stop = 1'b1; cyc(); stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        ball_captured = 1'b1; inductance = 1'b1;
        cyc();
        ball_captured = 1'b0; inductance = 1'b0;
        checks++;
        if (phase !== ST_BACKOFF || en_search !== 1'b1) begin
            errors++;
            $display("FAIL pend_backoff: phase=%0d es=%b required 4 1", phase, en_search);
        end
        repeat (BO - 1) cyc();
        cyc();
        checks++;
        if (phase !== ST_SEARCH) begin
            errors++;
            $display("FAIL pend_resume: phase=%0d required %0d", phase, ST_SEARCH);
        end
        cyc();
        checks++;
        if (phase !== ST_HANDOFF) begin
            errors++;
            $display("FAIL pend_handoff: phase=%0d required %0d", phase, ST_HANDOFF);
        end
    endtask

    task automatic test_watchdog();
        logic bad;
        goal_done = 1'b0;
        goto_goal();
        bad = 1'b0;
`ifdef GOAL_WATCHDOG_EN
        for (int i = 1; i < int'(GT); i++) begin
            cyc();
            if (phase !== ST_GOAL || wd_timeout !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wd_early: phase=%0d wd=%b required GOAL with wd 0", phase, wd_timeout);
        end
        cyc();
        checks++;
        if (wd_timeout !== 1'b1 || phase !== ST_HANDOFF) begin
            errors++;
            $display("FAIL wd_fire: wd=%b phase=%0d required 1 2", wd_timeout, phase);
        end
        cyc();
        checks++;
        if (wd_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wd_pulse: wd=%b required 0", wd_timeout);
        end
`else
        for (int i = 0; i < int'(GT) + 10; i++) begin
            cyc();
            if (phase !== ST_GOAL || wd_timeout !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL goal_unbounded: phase=%0d wd=%b required GOAL with wd 0", phase, wd_timeout);
        end
`endif
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++;
        if (phase !== ST_IDLE || motor_bus !== 8'h00 || en_search !== 1'b0 || en_goal !== 1'b0) begin
            errors++;
            $display("FAIL stop: phase=%0d bus=%h es=%b eg=%b required 0 00 0 0", phase, motor_bus, en_search, en_goal);
        end
    endtask

    task automatic test_random();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            start         = ($urandom_range(0, 3) == 0);
            stop          = ($urandom_range(0, 149) == 0);
            inductance    = ($urandom_range(0, 29) == 0);
            ball_captured = ($urandom_range(0, 9) == 0);
            if (pause) pause = ($urandom_range(0, 5) != 0);
            else       pause = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) goal_done = ~goal_done;
            search_bus = 8'($urandom);
            goal_bus   = 8'($urandom);
            cyc();
            checks++;
            if (phase !== m_st || motor_bus !== m_bus || en_search !== m_es ||
                en_goal !== m_eg || wd_timeout !== m_wd) begin
                errors++;
                $display("FAIL random_%0d: phase=%0d bus=%h es=%b eg=%b wd=%b required %0d %h %b %b %b",
                         n, phase, motor_bus, en_search, en_goal, wd_timeout,
                         m_st, m_bus, m_es, m_eg, m_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_search_grant();
        test_handoff_to_goal();
        test_goal_done();
        test_backoff();
        test_pause_backoff();
        test_ball_pending();
        test_watchdog();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
